mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one unified 32-bit memory port between the CPU instruction-fetch interface and the data-memory interface. The block sits between `cpu_top` and the single-ported Zynq BRAM/bridge. It presents per-port `*_ready` levels compatible with the core's global stall. It holds each completed response until the pipeline advances, so a stalled port is never re-issued.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (byte lanes = DATA_WIDTH/8 = 4)
- TIMEOUT_CYCLES, 256, ack watchdog limit (used only with MEM_ARB_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- imem_addr  in  ADDR_WIDTH  fetch address
- imem_read  in  1  fetch request (level)
- imem_read_data  out  32  fetched word, registered
- imem_ready  out  1  fetch complete or no fetch pending
- dmem_addr  in  ADDR_WIDTH  data address
- dmem_write_data  in  DATA_WIDTH  store data
- dmem_read  in  1  load request (level)
- dmem_write  in  1  store request (level)
- dmem_byte_enable  in  4  store byte lanes
- dmem_read_data  out  DATA_WIDTH  load data, registered
- dmem_ready  out  1  data access complete or none pending
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_WIDTH  read data, valid in the ack cycle
- mem_ack  in  1  access complete (one cycle)
- bus_error  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, D_ACC, I_ACC.
- Per-port flags: `i_done` and `d_done`.
- Pending request per port:
  - imem: `imem_read && !i_done`
  - dmem: `(dmem_read || dmem_write) && !d_done`
- IDLE:
  - If dmem is pending, capture the address, data and type into the mem_* registers and go to D_ACC. Data takes priority because it belongs to the older instruction.
  - Otherwise, if imem is pending, capture and go to I_ACC.
  - Otherwise stay in IDLE.
- D_ACC / I_ACC:
  - `mem_req = 1`; the mem_* registers are frozen.
  - On `mem_ack`: drop `mem_req`, latch `mem_rdata` into `dmem_read_data` (D_ACC) or `imem_read_data` (I_ACC), set that port's done flag, and return to IDLE.
- Port ready outputs (combinational):
  - `imem_ready = !imem_read || i_done`
  - `dmem_ready = !(dmem_read || dmem_write) || d_done`
- Retire: in any cycle where `imem_ready && dmem_ready`, both done flags clear at the next edge (pipeline advanced).
- Request encoding:
  - Store: `mem_we = 1`, `mem_be = dmem_byte_enable`.
  - Load and fetch: `mem_we = 0`, `mem_be = 4'hF`.
- If `dmem_read` and `dmem_write` are both high, the access is treated as a write.
- `dmem_read_data` is written only by completed loads. A store completion leaves it unchanged.

## Timing
- Reset values:
  - FSM in IDLE
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be = 0
  - imem_read_data = 32'h00000013 (NOP)
  - dmem_read_data = 0
  - i_done, d_done, bus_error = 0
- Reset asserted mid-access: `mem_req` drops asynchronously and the in-flight response is discarded.
- Latency:
  - Request seen in IDLE at edge N → `mem_req` high from N+1.
  - `mem_ack` in cycle M → ready high and data valid from M+1.
  - Minimum 2 cycles per access.
  - Both ports pending: dmem completes first, imem `mem_req` asserts the cycle after dmem's return to IDLE.
- `mem_ack` seen in IDLE is ignored.
- Port address changes while an access is in flight do not affect `mem_addr`. The captured address completes.
- Done flags survive stalls indefinitely. No re-issue occurs while the other port is still pending.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN` defined:
  - A counter runs in D_ACC/I_ACC and clears on entry.
  - If it reaches TIMEOUT_CYCLES-1 without `mem_ack`, the block drops `mem_req`, sets the port's done flag and returns to IDLE.
  - Substituted data: imem gets NOP 32'h00000013; a load gets 0.
  - `bus_error` sets and stays set until reset.
- Macro undefined:
  - The block waits indefinitely for `mem_ack`.
  - `bus_error` is tied to 0 and no counter logic exists.

## Structure
- Package `mem_arb_pkg`:
  - `arb_state_t` enum (IDLE, D_ACC, I_ACC)
  - `NOP_INST = 32'h00000013`
  - `FULL_BE = 4'hF`
- Sub-module `mem_arb_timeout`: watchdog counter with inputs clear/enable and output expired. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch only: `imem_read=1`, addr 0x100, ack 3 cycles later with 0xDEADBEEF → `mem_req` for 3 cycles, then `imem_ready=1` and `imem_read_data=0xDEADBEEF`; no re-issue until retire.
- Simultaneous fetch 0x200 + load 0x400 → load issued first (`mem_addr=0x400`, `mem_we=0`, `mem_be=F`), then fetch; `imem_ready` and `dmem_ready` both high only after both acks.
- Store 0x10, data 0x12345678, be 0x3 → `mem_we=1`, `mem_be=0x3`, `mem_wdata=0x12345678`; `dmem_read_data` unchanged.
- Fetch stalled by a pending load across 10 cycles → exactly one fetch `mem_req` issued; fetch data held stable until retire.
- Reset asserted while `mem_req=1` → `mem_req=0` immediately, `imem_read_data=0x13`, state IDLE after release.
- With `MEM_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=8, fetch with no ack → `mem_req` drops after 8 cycles, `imem_read_data=0x13`, `imem_ready=1`, `bus_error=1` sticky.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Optional ack watchdog is enabled with `define MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [3:0]  FULL_BE  = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU fetch/data ports and the shared memory port, bundled for the arbiter.
// master = arbiter side, slave = core + memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_read;
  logic [31:0]           imem_read_data;
  logic                  imem_ready;

  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_write_data;
  logic                  dmem_read;
  logic                  dmem_write;
  logic [3:0]            dmem_byte_enable;
  logic [DATA_WIDTH-1:0] dmem_read_data;
  logic                  dmem_ready;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  logic                  bus_error;

  modport master (
    input  imem_addr, imem_read,
    input  dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable,
    input  mem_rdata, mem_ack,
    output imem_read_data, imem_ready,
    output dmem_read_data, dmem_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output bus_error
  );

  modport slave (
    output imem_addr, imem_read,
    output dmem_addr, dmem_write_data, dmem_read, dmem_write, dmem_byte_enable,
    output mem_rdata, mem_ack,
    input  imem_read_data, imem_ready,
    input  dmem_read_data, dmem_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  bus_error
  );
endinterface

// File: rtl/mem_port_arbiter_timeout.sv
// Ack watchdog: counts cycles while enabled, flags when LIMIT-1 is reached.
// Used by mem_port_arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, data first.
// Completed responses are held until both ports are ready. Watchdog: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_D_ACC = D_ACC;
  localparam logic [1:0] S_I_ACC = I_ACC;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           irdata_q, irdata_d;
  logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;

  logic i_pend, d_pend, i_ready, d_ready, retire, expired;

  assign i_pend  = bus.imem_read && !i_done_q;
  assign d_pend  = (bus.dmem_read || bus.dmem_write) && !d_done_q;
  assign i_ready = !bus.imem_read || i_done_q;
  assign d_ready = !(bus.dmem_read || bus.dmem_write) || d_done_q;
  assign retire  = i_ready && d_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  logic bus_err_q, bus_err_d;

  mem_arb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == S_IDLE),
    .enable  (state_q != S_IDLE),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'h0;
      irdata_q <= NOP_INST;
      drdata_q <= '0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err_q <= bus_err_d;
`endif
    end
  end

  // Next-state: issue from IDLE, complete on ack (or watchdog expiry)
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    i_done_d = i_done_q;
    d_done_d = d_done_q;
`ifdef MEM_ARB_TIMEOUT_EN
    bus_err_d = bus_err_q;
`endif

    // Retire clears first so a completion in the same cycle still sticks
    if (retire) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (d_pend) begin
          state_d = S_D_ACC;
          req_d   = 1'b1;
          we_d    = bus.dmem_write;
          addr_d  = bus.dmem_addr;
          wdata_d = bus.dmem_write_data;
          be_d    = bus.dmem_write ? bus.dmem_byte_enable : FULL_BE;
        end else if (i_pend) begin
          state_d = S_I_ACC;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = bus.imem_addr;
          be_d    = FULL_BE;
        end
      end
      S_D_ACC: begin
        if (bus.mem_ack || expired) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          d_done_d = 1'b1;
          if (!we_q) begin
            drdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          if (!bus.mem_ack) bus_err_d = 1'b1;
`endif
        end
      end
      S_I_ACC: begin
        if (bus.mem_ack || expired) begin
          state_d  = S_IDLE;
          req_d    = 1'b0;
          i_done_d = 1'b1;
          irdata_d = bus.mem_ack ? 32'(bus.mem_rdata) : NOP_INST;
`ifdef MEM_ARB_TIMEOUT_EN
          if (!bus.mem_ack) bus_err_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus.mem_req        = req_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_be         = be_q;
  assign bus.imem_read_data = irdata_q;
  assign bus.dmem_read_data = drdata_q;
  assign bus.imem_ready     = i_ready;
  assign bus.dmem_ready     = d_ready;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.bus_error      = bus_err_q;
`else
  assign bus.bus_error      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected requests/responses are queued
// by the stimulus and consumed by monitors watching the memory and CPU ports.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic [3:0]  be;
    int          len;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  req_t        exp_req[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int          lat_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          spurious_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Memory model: per-access ack latency from lat_q (0 = never ack)
  int cnt = 0;
  int cur_lat = 0;
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (cnt == 0) cur_lat = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        cnt++;
        if (cur_lat != 0 && cnt == cur_lat) begin
          logic [31:0] w;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_rd(bus.mem_addr);
          if (bus.mem_we) begin
            w = mem_rd(bus.mem_addr);
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            mem[bus.mem_addr] = w;
          end
        end
      end else begin
        cnt = 0;
      end
      if (spurious_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
      end
    end
  end

  // Request monitor: fields at issue, duration and address stability
  bit   in_req = 1'b0;
  bit   addr_bad = 1'b0;
  int   req_len = 0;
  req_t cur;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_len  = 0;
        addr_bad = 1'b0;
        if (exp_req.size() == 0) begin
          flag_fail("req_unexpected");
          cur.addr = bus.mem_addr;
          cur.len  = 0;
        end else begin
          cur = exp_req.pop_front();
          check("req_we", 32'(bus.mem_we), 32'(cur.we));
          check("req_addr", bus.mem_addr, cur.addr);
          check("req_be", 32'(bus.mem_be), 32'(cur.be));
          if (cur.chk_wdata) check("req_wdata", bus.mem_wdata, cur.wdata);
        end
      end
      req_len++;
      if (bus.mem_addr !== cur.addr) addr_bad = 1'b1;
    end else if (in_req) begin
      in_req = 1'b0;
      if (cur.len != 0) check("req_len", 32'(req_len), 32'(cur.len));
      check("req_addr_stable", 32'(addr_bad), 32'h0);
    end
  end

  // Response monitor: a port's ready rising under a held request is a completion
  logic iread_d = 1'b0, iready_d = 1'b1, dany_d = 1'b0, dready_d = 1'b1;
  logic dany;
  always @(negedge clk) begin
    dany = bus.dmem_read || bus.dmem_write;
    if (bus.imem_read && bus.imem_ready && iread_d && !iready_d) begin
      if (exp_i.size() == 0) flag_fail("iresp_unexpected");
      else check("iresp_data", bus.imem_read_data, exp_i.pop_front());
    end
    if (dany && bus.dmem_ready && dany_d && !dready_d) begin
      if (exp_d.size() == 0) flag_fail("dresp_unexpected");
      else check("dresp_data", bus.dmem_read_data, exp_d.pop_front());
    end
    iread_d  = bus.imem_read;
    iready_d = bus.imem_ready;
    dany_d   = dany;
    dready_d = bus.dmem_ready;
  end

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return bus.imem_ready && bus.dmem_ready;
      1:       return bus.imem_ready;
      2:       return bus.dmem_ready;
      default: return bus.mem_req;
    endcase
  endfunction

  task automatic wait_for(input string name, input int sel, input int budget);
    int n = 0;
    @(negedge clk);
    while (!sel_sig(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sel_sig(sel)), 32'h1);
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit chk, input logic [3:0] be, input int len);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.chk_wdata = chk; r.be = be; r.len = len;
    exp_req.push_back(r);
  endtask

  task automatic data_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input int lat,
                             input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    lat_q.push_back(lat);
    push_req(wr, addr, wdata, wr, exp_be, lat);
    exp_d.push_back(exp_rdata);
    bus.dmem_addr = addr; bus.dmem_write_data = wdata; bus.dmem_byte_enable = be;
    bus.dmem_read = rd; bus.dmem_write = wr;
    wait_for("data_done", 0, lat + 20);
    @(posedge clk); #1;
    bus.dmem_read = 1'b0; bus.dmem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic fetch_access(input logic [31:0] addr, input int lat, input logic [31:0] exp_rdata);
    lat_q.push_back(lat);
    push_req(1'b0, addr, 32'h0, 1'b0, 4'hF, lat);
    exp_i.push_back(exp_rdata);
    bus.imem_addr = addr; bus.imem_read = 1'b1;
    wait_for("fetch_done", 0, lat + 20);
    @(posedge clk); #1;
    bus.imem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_addr = 32'h0; bus.imem_read = 1'b0;
    bus.dmem_addr = 32'h0; bus.dmem_write_data = 32'h0;
    bus.dmem_read = 1'b0; bus.dmem_write = 1'b0; bus.dmem_byte_enable = 4'h0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h00A00093;
    mem[32'h400] = 32'hCAFEF00D;
    mem[32'h010] = 32'hAAAAAAAA;
    mem[32'h020] = 32'h00000000;
    mem[32'h300] = 32'h00000513;
    mem[32'h500] = 32'h55AA55AA;

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_be", 32'(bus.mem_be), 32'h0);
    check("rst_imem_data", bus.imem_read_data, 32'h00000013);
    check("rst_dmem_data", bus.dmem_read_data, 32'h0);
    check("rst_ready", 32'({bus.imem_ready, bus.dmem_ready}), 32'h3);
    check("rst_bus_error", 32'(bus.bus_error), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fetch only, address moves mid-flight; captured address must complete
    lat_q.push_back(3);
    push_req(1'b0, 32'h100, 32'h0, 1'b0, 4'hF, 3);
    exp_i.push_back(32'hDEADBEEF);
    bus.imem_addr = 32'h100; bus.imem_read = 1'b1;
    wait_for("t1_req", 3, 10);
    @(posedge clk); #1 bus.imem_addr = 32'h104;
    wait_for("t1_iready", 1, 20);
    @(posedge clk); #1 bus.imem_read = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_hold", bus.imem_read_data, 32'hDEADBEEF);
    check("t1_noreq", 32'(bus.mem_req), 32'h0);
    @(posedge clk); #1;

    // Simultaneous fetch + load: load first, ready pair only after both
    lat_q.push_back(2); lat_q.push_back(2);
    push_req(1'b0, 32'h400, 32'h0, 1'b0, 4'hF, 2);
    push_req(1'b0, 32'h200, 32'h0, 1'b0, 4'hF, 2);
    exp_d.push_back(32'hCAFEF00D);
    exp_i.push_back(32'h00A00093);
    bus.imem_addr = 32'h200; bus.imem_read = 1'b1;
    bus.dmem_addr = 32'h400; bus.dmem_read = 1'b1;
    wait_for("t2_dready", 2, 20);
    check("t2_iready_low", 32'(bus.imem_ready), 32'h0);
    wait_for("t2_both", 0, 20);
    @(posedge clk); #1 bus.imem_read = 1'b0; bus.dmem_read = 1'b0;
    @(posedge clk); #1;

    // Stores leave load data alone; read+write together is a write
    data_access(1'b0, 1'b1, 32'h10, 32'h12345678, 4'h3, 2, 4'h3, 32'hCAFEF00D);
    data_access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 2, 4'hF, 32'hAAAA5678);
    data_access(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hC, 3, 4'hC, 32'hAAAA5678);
    data_access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 2, 4'hF, 32'h11220000);

    // Ack while idle must be ignored
    spurious_ack = 1'b1;
    @(posedge clk); #1 spurious_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_noreq", 32'(bus.mem_req), 32'h0);
    check("t5_idata", bus.imem_read_data, 32'h00A00093);
    check("t5_ddata", bus.dmem_read_data, 32'h11220000);
    @(posedge clk); #1;

    // Fetch completes, then a long load stalls it: no second fetch issue
    lat_q.push_back(3);
    push_req(1'b0, 32'h300, 32'h0, 1'b0, 4'hF, 3);
    exp_i.push_back(32'h00000513);
    bus.imem_addr = 32'h300; bus.imem_read = 1'b1;
    wait_for("t4_freq", 3, 10);
    @(posedge clk); #1;
    lat_q.push_back(10);
    push_req(1'b0, 32'h500, 32'h0, 1'b0, 4'hF, 10);
    exp_d.push_back(32'h55AA55AA);
    bus.dmem_addr = 32'h500; bus.dmem_read = 1'b1;
    wait_for("t4_iready", 1, 20);
    wait_for("t4_dready", 2, 30);
    check("t4_idata_held", bus.imem_read_data, 32'h00000513);
    @(posedge clk); #1 bus.imem_read = 1'b0; bus.dmem_read = 1'b0;
    @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Unacknowledged fetch: watchdog substitutes NOP and sets sticky error
    lat_q.push_back(0);
    push_req(1'b0, 32'h700, 32'h0, 1'b0, 4'hF, int'(TB_TIMEOUT));
    exp_i.push_back(32'h00000013);
    bus.imem_addr = 32'h700; bus.imem_read = 1'b1;
    wait_for("t7_iready", 1, 40);
    check("t7_bus_error", 32'(bus.bus_error), 32'h1);
    @(posedge clk); #1 bus.imem_read = 1'b0;
    repeat (4) @(negedge clk);
    check("t7_bus_error_sticky", 32'(bus.bus_error), 32'h1);
    @(posedge clk); #1;
`endif

    // Reset mid-access: request drops at once, response discarded
    lat_q.push_back(0);
    push_req(1'b0, 32'h600, 32'h0, 1'b0, 4'hF, 0);
    bus.imem_addr = 32'h600; bus.imem_read = 1'b1;
    wait_for("t6_req", 3, 10);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_req_async", 32'(bus.mem_req), 32'h0);
    check("t6_idata_nop", bus.imem_read_data, 32'h00000013);
    check("t6_ddata_zero", bus.dmem_read_data, 32'h0);
    check("t6_bus_error", 32'(bus.bus_error), 32'h0);
    bus.imem_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_noreq", 32'(bus.mem_req), 32'h0);
    check("t6_idle_ready", 32'({bus.imem_ready, bus.dmem_ready}), 32'h3);
    @(posedge clk); #1;
    fetch_access(32'h100, 2, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    check("end_req_q", 32'(exp_req.size()), 32'h0);
    check("end_iresp_q", 32'(exp_i.size()), 32'h0);
    check("end_dresp_q", 32'(exp_d.size()), 32'h0);
    check("end_bus_error", 32'(bus.bus_error), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
